// File: rtl/phase_error_detector_if.sv
// Pulse-stream inputs and phase-error outputs of the phase error detector.
// The master side drives the pulse streams; the slave side is the detector.
interface phase_error_detector_if #(
  parameter int ERR_W = 8
);
  logic             ref_in;
  logic             fb_in;
  logic [ERR_W-1:0] pd_out;
  logic             pd_valid;
  logic             slip;
  logic             locked;

  modport master (
    output ref_in, fb_in,
    input  pd_out, pd_valid, slip, locked
  );

  modport slave (
    input  ref_in, fb_in,
    output pd_out, pd_valid, slip, locked
  );
endinterface

// File: rtl/phase_error_detector.sv
// Rising-edge phase detector: measures ref-to-fb edge spacing in clk cycles,
// emits a saturated signed error, flags cycle slips and tracks lock.
module phase_error_detector #(
  parameter int ERR_W    = 8,
  parameter int MAX_WAIT = 127,
  parameter int LOCK_TH  = 2,
  parameter int LOCK_CNT = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  phase_error_detector_if.slave  pd
);
  localparam int LCW = $clog2(LOCK_CNT + 1);
  localparam logic [7:0]     MAXW     = 8'(MAX_WAIT);
  localparam logic [7:0]     TH8      = 8'(LOCK_TH);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, REF_LEAD, FB_LEAD} state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ref_q, fb_q;
  logic [ERR_W-1:0] pd_out_q, pd_out_d;
  logic             pd_valid_q, pd_valid_d;
  logic             slip_q, slip_d;
  logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
  logic             locked_q, locked_d;

  logic             ref_rise, fb_rise;
  logic             close, neg;
  logic [7:0]       mag;
  logic [ERR_W-1:0] err_abs, err;

  assign ref_rise = pd.ref_in & ~ref_q;
  assign fb_rise  = pd.fb_in  & ~fb_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    close   = 1'b0;
    neg     = 1'b0;
    mag     = '0;
    slip_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ref_rise && fb_rise) begin
          close = 1'b1;
        end else if (ref_rise) begin
          state_d = REF_LEAD;
          cnt_d   = 8'd1;
        end else if (fb_rise) begin
          state_d = FB_LEAD;
          cnt_d   = 8'd1;
        end
      end
      REF_LEAD, FB_LEAD: begin
        neg = (state_q == FB_LEAD);
        // "close" is the lagging stream's edge; "lead" is a repeat of the leader
        if ((state_q == REF_LEAD) ? fb_rise : ref_rise) begin
          close   = 1'b1;
          mag     = (cnt_q > MAXW) ? MAXW : cnt_q;
          state_d = IDLE;
          cnt_d   = '0;
        end else if ((state_q == REF_LEAD) ? ref_rise : fb_rise) begin
          close  = 1'b1;
          mag    = MAXW;
          slip_d = 1'b1;
          cnt_d  = 8'd1;
        end else if (cnt_q >= MAXW) begin
          close   = 1'b1;
          mag     = MAXW;
          slip_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign err_abs = ERR_W'(mag);
  assign err     = neg ? (~err_abs + 1'b1) : err_abs;

  always_comb begin
    pd_out_d   = close ? err : pd_out_q;
    pd_valid_d = close;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (close) begin
      if (!slip_d && (mag <= TH8)) begin
        if (lock_cnt_q < LOCK_MAX) lock_cnt_d = lock_cnt_q + 1'b1;
        locked_d = (lock_cnt_d == LOCK_MAX);
      end else begin
        lock_cnt_d = '0;
        locked_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ref_q      <= 1'b1;
      fb_q       <= 1'b1;
      pd_out_q   <= '0;
      pd_valid_q <= 1'b0;
      slip_q     <= 1'b0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ref_q      <= pd.ref_in;
      fb_q       <= pd.fb_in;
      pd_out_q   <= pd_out_d;
      pd_valid_q <= pd_valid_d;
      slip_q     <= slip_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign pd.pd_out   = pd_out_q;
  assign pd.pd_valid = pd_valid_q;
  assign pd.slip     = slip_q;
  assign pd.locked   = locked_q;
endmodule

// File: tb/tb_phase_error_detector.sv
// Directed bench for phase_error_detector: edge spacing, timeouts, slips,
// lock acquisition/loss and reset abandonment.
module tb_phase_error_detector;
  logic clk;
  logic rstn;
  int   n_tests;
  int   n_fail;
  int   seen_valid;

  phase_error_detector_if #(.ERR_W(8)) bus ();

  phase_error_detector #(
    .ERR_W   (8),
    .MAX_WAIT(127),
    .LOCK_TH (2),
    .LOCK_CNT(16)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .pd  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, settle just after it.
  task automatic step(input logic r, input logic f);
    bus.ref_in = r;
    bus.fb_in  = f;
    @(posedge clk);
    #1;
    if (bus.pd_valid === 1'b1) seen_valid++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  // One measurement with signed spacing e (positive: ref first); ends on the closing edge.
  task automatic meas(input int e);
    if (e == 0) begin
      step(1'b1, 1'b1);
    end else if (e > 0) begin
      step(1'b1, 1'b0);
      idle(e - 1);
      step(1'b0, 1'b1);
    end else begin
      step(1'b0, 1'b1);
      idle(-e - 1);
      step(1'b1, 1'b0);
    end
  endtask

  initial begin
    int errs [16];
    logic [7:0] e8;
    n_tests    = 0;
    n_fail     = 0;
    seen_valid = 0;
    errs = '{0, 1, 2, -1, -2, 0, 1, -1, 2, -2, 0, 0, 1, 2, -1, -2};

    // Reset with both inputs high
    rstn = 1'b0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("rst_pd_out",   32'(bus.pd_out),   32'h0);
    chk("rst_pd_valid", 32'(bus.pd_valid), 32'h0);
    chk("rst_slip",     32'(bus.slip),     32'h0);
    chk("rst_locked",   32'(bus.locked),   32'h0);

    rstn = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    chk("high_at_release_no_valid", 32'(seen_valid), 32'h0);
    chk("high_at_release_pd_out",   32'(bus.pd_out), 32'h0);
    idle(3);

    // ref leads by 5
    seen_valid = 0;
    meas(5);
    chk("lag5_pd_out",   32'(bus.pd_out),   32'h05);
    chk("lag5_pd_valid", 32'(bus.pd_valid), 32'h1);
    chk("lag5_once",     32'(seen_valid),   32'h1);
    idle(1);
    chk("lag5_valid_drop", 32'(bus.pd_valid), 32'h0);
    chk("lag5_hold",       32'(bus.pd_out),   32'h05);

    // fb leads by 3
    meas(-3);
    chk("lead3_pd_out",   32'(bus.pd_out),   32'hFD);
    chk("lead3_pd_valid", 32'(bus.pd_valid), 32'h1);
    idle(1);

    // Coincident rises
    meas(0);
    chk("coinc_pd_out",   32'(bus.pd_out),   32'h00);
    chk("coinc_pd_valid", 32'(bus.pd_valid), 32'h1);
    idle(1);

    // ref timeout at 127
    seen_valid = 0;
    step(1'b1, 1'b0);
    idle(126);
    chk("rto_no_early_valid", 32'(seen_valid), 32'h0);
    idle(1);
    chk("rto_pd_out",   32'(bus.pd_out),   32'h7F);
    chk("rto_slip",     32'(bus.slip),     32'h1);
    chk("rto_pd_valid", 32'(bus.pd_valid), 32'h1);
    idle(1);
    chk("rto_slip_drop", 32'(bus.slip), 32'h0);
    // back in IDLE: fb now leads
    meas(-2);
    chk("rto_idle_after", 32'(bus.pd_out), 32'hFE);
    idle(1);

    // fb timeout at 127
    step(1'b0, 1'b1);
    idle(127);
    chk("fto_pd_out", 32'(bus.pd_out), 32'h81);
    chk("fto_slip",   32'(bus.slip),   32'h1);
    idle(1);

    // Duplicate ref edge 40 cycles later, then fb 3 cycles after that
    step(1'b1, 1'b0);
    idle(39);
    step(1'b1, 1'b0);
    chk("dup_pd_out",   32'(bus.pd_out),   32'h7F);
    chk("dup_slip",     32'(bus.slip),     32'h1);
    chk("dup_pd_valid", 32'(bus.pd_valid), 32'h1);
    idle(2);
    step(1'b0, 1'b1);
    chk("dup_then_fb_pd_out", 32'(bus.pd_out), 32'h03);
    chk("dup_then_fb_slip",   32'(bus.slip),   32'h0);
    idle(1);

    // Lock acquisition over 16 small errors
    for (int i = 0; i < 16; i++) begin
      meas(errs[i]);
      e8 = 8'(errs[i]);
      chk("lock_pd_out", 32'(bus.pd_out), 32'(e8));
      chk("lock_locked", 32'(bus.locked), (i == 15) ? 32'h1 : 32'h0);
      idle(1);
    end
    chk("lock_hold", 32'(bus.locked), 32'h1);
    meas(3);
    chk("unlock_pd_out", 32'(bus.pd_out), 32'h03);
    chk("unlock_locked", 32'(bus.locked), 32'h0);
    idle(1);

    // Reset in REF_LEAD with cnt = 50
    step(1'b1, 1'b0);
    idle(49);
    rstn = 1'b0;
    idle(1);
    chk("midrst_pd_out",   32'(bus.pd_out),   32'h0);
    chk("midrst_pd_valid", 32'(bus.pd_valid), 32'h0);
    chk("midrst_slip",     32'(bus.slip),     32'h0);
    chk("midrst_locked",   32'(bus.locked),   32'h0);
    rstn = 1'b1;
    seen_valid = 0;
    idle(2);
    step(1'b0, 1'b1);
    idle(5);
    chk("midrst_no_stale", 32'(seen_valid), 32'h0);
    chk("midrst_pd_out2",  32'(bus.pd_out), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
